alu_ctrl_fsm: RTL and testbench

ALU_CTRL_FSM -- requirements
Module: alu_ctrl_fsm

---
 rtl/alu_ctrl_fsm_pkg.sv | 45 ++++
 rtl/alu_ctrl_fsm_imm_extend.sv | 22 ++
 rtl/alu_ctrl_fsm.sv | 133 +++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_fsm_pkg.sv
// Shared definitions for the ALU control FSM: instruction field positions,
// op/ext encodings, controller states and the immediate-extension rule.
package alu_ctrl_fsm_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned FIELD_W   = 4;
    localparam int unsigned FLAG_W    = 5;
    localparam int unsigned OPCODE_W  = 5;
    localparam int unsigned IMM_SRC_W = 8;

    // Instruction word field bit positions
    localparam int unsigned OP_MSB    = 15;
    localparam int unsigned OP_LSB    = 12;
    localparam int unsigned RDEST_MSB = 11;
    localparam int unsigned RDEST_LSB = 8;
    localparam int unsigned EXT_MSB   = 7;
    localparam int unsigned EXT_LSB   = 4;
    localparam int unsigned RSRC_MSB  = 3;
    localparam int unsigned RSRC_LSB  = 0;
    localparam int unsigned IMM_MSB   = 7;
    localparam int unsigned IMM_LSB   = 0;

    // Op / Ext encodings
    localparam logic [FIELD_W-1:0] OP_REG     = 4'b0000;
    localparam logic [FIELD_W-1:0] OP_ANDI    = 4'b0001;
    localparam logic [FIELD_W-1:0] OP_ORI     = 4'b0010;
    localparam logic [FIELD_W-1:0] OP_XORI    = 4'b0011;
    localparam logic [FIELD_W-1:0] OP_ADD     = 4'b0101;
    localparam logic [FIELD_W-1:0] OP_CMP     = 4'b1011;
    localparam logic [FIELD_W-1:0] OP_MOV     = 4'b1101;
    localparam logic [FIELD_W-1:0] OP_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK
    } state_t;

    // Logical immediates are zero-extended; all other immediates sign-extended
    function automatic logic imm_is_zero_ext(input logic [FIELD_W-1:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/alu_ctrl_fsm_imm_extend.sv
// Combinational immediate extender.
// Ports: op    - instruction op field, selects zero or sign extension
//        raw   - 8-bit immediate from the instruction word
//        imm_c - immediate extended to IMM_W bits
module alu_ctrl_fsm_imm_extend
    import alu_ctrl_fsm_pkg::*;
#(
    parameter int unsigned IMM_W = 16
) (
    input  logic [FIELD_W-1:0]   op,
    input  logic [IMM_SRC_W-1:0] raw,
    output logic [IMM_W-1:0]     imm_c
);

    always_comb begin
        imm_c = IMM_W'($signed(raw));
        if (imm_is_zero_ext(op)) begin
            imm_c = IMM_W'(raw);
        end
    end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// ALU control FSM: accepts one instruction word in IDLE, decodes it into
// register addresses / op select / immediate, latches ALU flags and pulses
// the register-file write enable. IDLE -> DECODE -> EXECUTE -> WRITEBACK.
// Ports: Clk, Rst (sync, active-low)
//        InstrIn/InstrValid/InstrReady - instruction handshake
//        Flags                         - ALU flags for the current op
//        RdestRegLoc/RsrcRegLoc        - register-file addresses
//        Imm/Imm_s                     - immediate operand and its select
//        OpCode                        - ALU operation select
//        En                            - register-file write enable pulse
//        Psr                           - latched flag register
//        Illegal                       - pulse on undefined instruction
module alu_ctrl_fsm
    import alu_ctrl_fsm_pkg::*;
#(
    parameter int unsigned IMM_W = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [INSTR_W-1:0]  InstrIn,
    input  logic                InstrValid,
    output logic                InstrReady,
    input  logic [FLAG_W-1:0]   Flags,
    output logic [FIELD_W-1:0]  RdestRegLoc,
    output logic [FIELD_W-1:0]  RsrcRegLoc,
    output logic [IMM_W-1:0]    Imm,
    output logic                Imm_s,
    output logic [OPCODE_W-1:0] OpCode,
    output logic                En,
    output logic [FLAG_W-1:0]   Psr,
    output logic                Illegal
);

    state_t               state, state_d;
    logic [FIELD_W-1:0]   eff_op, eff_op_d;
    logic                 ready_d, en_d, illegal_d, imm_s_d;
    logic [FLAG_W-1:0]    psr_d;
    logic [OPCODE_W-1:0]  opcode_d;
    logic [IMM_W-1:0]     imm_d, imm_ext;
    logic [FIELD_W-1:0]   rdest_d, rsrc_d;

    logic [FIELD_W-1:0]   in_op, in_ext;

    assign in_op  = InstrIn[OP_MSB:OP_LSB];
    assign in_ext = InstrIn[EXT_MSB:EXT_LSB];

    alu_ctrl_fsm_imm_extend #(
        .IMM_W (IMM_W)
    ) u_imm_extend (
        .op    (in_op),
        .raw   (InstrIn[IMM_MSB:IMM_LSB]),
        .imm_c (imm_ext)
    );

    // State and registered outputs
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state       <= ST_IDLE;
            eff_op      <= '0;
            InstrReady  <= 1'b1;
            En          <= 1'b0;
            Illegal     <= 1'b0;
            Psr         <= '0;
            OpCode      <= '0;
            Imm         <= '0;
            Imm_s       <= 1'b0;
            RdestRegLoc <= '0;
            RsrcRegLoc  <= '0;
        end else begin
            state       <= state_d;
            eff_op      <= eff_op_d;
            InstrReady  <= ready_d;
            En          <= en_d;
            Illegal     <= illegal_d;
            Psr         <= psr_d;
            OpCode      <= opcode_d;
            Imm         <= imm_d;
            Imm_s       <= imm_s_d;
            RdestRegLoc <= rdest_d;
            RsrcRegLoc  <= rsrc_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d   = state;
        eff_op_d  = eff_op;
        en_d      = 1'b0;
        illegal_d = 1'b0;
        psr_d     = Psr;
        opcode_d  = OpCode;
        imm_d     = Imm;
        imm_s_d   = Imm_s;
        rdest_d   = RdestRegLoc;
        rsrc_d    = RsrcRegLoc;

        case (state)
            ST_IDLE: begin
                if (InstrValid && InstrReady) begin
                    state_d   = ST_DECODE;
                    // Register form takes its ALU op from Ext
                    eff_op_d  = (in_op == OP_REG) ? in_ext : in_op;
                    opcode_d  = OPCODE_W'(eff_op_d);
                    imm_s_d   = (in_op != OP_REG);
                    imm_d     = imm_ext;
                    rdest_d   = InstrIn[RDEST_MSB:RDEST_LSB];
                    rsrc_d    = InstrIn[RSRC_MSB:RSRC_LSB];
                    illegal_d = (in_op == OP_ILLEGAL);
                end
            end
            ST_DECODE: begin
                // Illegal is high only while decoding an undefined word
                state_d = Illegal ? ST_IDLE : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_d = ST_WRITEBACK;
                if (eff_op != OP_MOV) begin
                    psr_d = Flags;
                end
                en_d = (eff_op != OP_CMP);
            end
            ST_WRITEBACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed self-checking bench for alu_ctrl_fsm.
module tb_alu_ctrl_fsm;
    import alu_ctrl_fsm_pkg::*;

    localparam int unsigned IMM_W = 16;

    logic              Clk;
    logic              Rst;
    logic [15:0]       InstrIn;
    logic              InstrValid;
    logic              InstrReady;
    logic [4:0]        Flags;
    logic [3:0]        RdestRegLoc;
    logic [3:0]        RsrcRegLoc;
    logic [IMM_W-1:0]  Imm;
    logic              Imm_s;
    logic [4:0]        OpCode;
    logic              En;
    logic [4:0]        Psr;
    logic              Illegal;

    int n_checks = 0;
    int n_pass   = 0;

    alu_ctrl_fsm #(
        .IMM_W (IMM_W)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .InstrIn     (InstrIn),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .Flags       (Flags),
        .RdestRegLoc (RdestRegLoc),
        .RsrcRegLoc  (RsrcRegLoc),
        .Imm         (Imm),
        .Imm_s       (Imm_s),
        .OpCode      (OpCode),
        .En          (En),
        .Psr         (Psr),
        .Illegal     (Illegal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Issue one word from IDLE and follow it through WRITEBACK
    task automatic run_op(input string tag, input logic [15:0] word, input logic [4:0] flags,
                          input logic [4:0] exp_op, input logic exp_imm_s,
                          input logic [15:0] exp_imm, input logic exp_en,
                          input logic [4:0] exp_psr);
        logic [3:0] exp_rdest;
        logic [3:0] exp_rsrc;
        exp_rdest  = word[11:8];
        exp_rsrc   = word[3:0];
        Flags      = flags;
        InstrIn    = word;
        InstrValid = 1'b1;
        tick();                         // accept edge -> DECODE
        InstrValid = 1'b0;
        InstrIn    = 16'hFFFF;
        check({tag, "_opcode"}, 32'(OpCode), 32'(exp_op));
        check({tag, "_imm_s"}, 32'(Imm_s), 32'(exp_imm_s));
        check({tag, "_rdest"}, 32'(RdestRegLoc), 32'(exp_rdest));
        check({tag, "_ready_dec"}, 32'(InstrReady), 32'd0);
        check({tag, "_illegal"}, 32'(Illegal), 32'd0);
        if (exp_imm_s) check({tag, "_imm"}, 32'(Imm), 32'(exp_imm));
        else           check({tag, "_rsrc"}, 32'(RsrcRegLoc), 32'(exp_rsrc));
        tick();                         // EXECUTE
        check({tag, "_en_exec"}, 32'(En), 32'd0);
        tick();                         // WRITEBACK
        check({tag, "_en_wb"}, 32'(En), 32'(exp_en));
        check({tag, "_psr"}, 32'(Psr), 32'(exp_psr));
        check({tag, "_opcode_wb"}, 32'(OpCode), 32'(exp_op));
        tick();                         // back to IDLE
        check({tag, "_en_idle"}, 32'(En), 32'd0);
        check({tag, "_ready_idle"}, 32'(InstrReady), 32'd1);
    endtask

    initial begin
        Rst        = 1'b0;
        InstrIn    = 16'h0000;
        InstrValid = 1'b0;
        Flags      = 5'b0;
        tick();
        tick();
        Rst = 1'b1;
        check("rst_ready", 32'(InstrReady), 32'd1);
        check("rst_en", 32'(En), 32'd0);
        check("rst_illegal", 32'(Illegal), 32'd0);
        check("rst_psr", 32'(Psr), 32'd0);
        check("rst_opcode", 32'(OpCode), 32'd0);
        check("rst_imm", 32'(Imm), 32'd0);
        check("rst_imm_s", 32'(Imm_s), 32'd0);
        check("rst_rdest", 32'(RdestRegLoc), 32'd0);
        check("rst_rsrc", 32'(RsrcRegLoc), 32'd0);

        run_op("add_reg", 16'h0253, 5'b00010, {1'b0, OP_ADD}, 1'b0, 16'h0000, 1'b1, 5'b00010);
        run_op("addi_sx", 16'h51F0, 5'b10101, 5'h05, 1'b1, 16'hFFF0, 1'b1, 5'b10101);
        run_op("andi_zx", 16'h11F0, 5'b00001, 5'h01, 1'b1, 16'h00F0, 1'b1, 5'b00001);
        run_op("cmpi", 16'hB107, 5'b01000, 5'h0B, 1'b1, 16'h0007, 1'b0, 5'b01000);
        run_op("movi", 16'hD107, 5'b11111, 5'h0D, 1'b1, 16'h0007, 1'b1, 5'b01000);

        // Undefined op: one-cycle Illegal, straight back to IDLE
        Flags      = 5'b10000;
        InstrIn    = 16'hF000;
        InstrValid = 1'b1;
        tick();
        InstrValid = 1'b0;
        check("ill_pulse", 32'(Illegal), 32'd1);
        check("ill_en_dec", 32'(En), 32'd0);
        tick();
        check("ill_pulse_end", 32'(Illegal), 32'd0);
        check("ill_ready", 32'(InstrReady), 32'd1);
        check("ill_en", 32'(En), 32'd0);
        tick();
        check("ill_en_late", 32'(En), 32'd0);
        check("ill_psr", 32'(Psr), 32'(5'b01000));

        // Reset held for two cycles while an instruction is in EXECUTE
        Flags      = 5'b00111;
        InstrIn    = 16'h0253;
        InstrValid = 1'b1;
        tick();
        InstrValid = 1'b0;
        tick();
        Rst = 1'b0;
        tick();
        check("mid_rst_ready", 32'(InstrReady), 32'd1);
        check("mid_rst_en", 32'(En), 32'd0);
        check("mid_rst_psr", 32'(Psr), 32'd0);
        tick();
        Rst = 1'b1;
        check("mid_rst_opcode", 32'(OpCode), 32'd0);
        tick();
        check("mid_rst_after_ready", 32'(InstrReady), 32'd1);
        check("mid_rst_after_en", 32'(En), 32'd0);
        check("mid_rst_after_psr", 32'(Psr), 32'd0);

        // Reset wins over a valid word in the same cycle
        Rst        = 1'b0;
        InstrIn    = 16'h0253;
        InstrValid = 1'b1;
        tick();
        InstrValid = 1'b0;
        Rst        = 1'b1;
        check("rst_prio_ready", 32'(InstrReady), 32'd1);
        check("rst_prio_rdest", 32'(RdestRegLoc), 32'd0);
        check("rst_prio_opcode", 32'(OpCode), 32'd0);

        // InstrValid held with a new word every cycle: only words 0 and 4 land
        Flags      = 5'b00011;
        InstrValid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] rd;
            rd      = 4'(k + 8);
            InstrIn = {4'h0, rd, 8'h12};
            tick();
            check($sformatf("b2b_rdest_%0d", k), 32'(RdestRegLoc), (k < 4) ? 32'd8 : 32'd12);
            check($sformatf("b2b_ready_%0d", k), 32'(InstrReady), ((k % 4) == 3) ? 32'd1 : 32'd0);
            check($sformatf("b2b_en_%0d", k), 32'(En), ((k % 4) == 2) ? 32'd1 : 32'd0);
        end
        InstrValid = 1'b0;
        tick();
        check("b2b_idle_ready", 32'(InstrReady), 32'd1);
        check("b2b_opcode", 32'(OpCode), 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
